ofdm_sc_mapper: RTL and testbench

OFDM_SC_MAPPER -- requirements
Module: ofdm_sc_mapper

---
 rtl/ofdm_map_pkg.sv | 28 ++
 rtl/pilot_lfsr.sv | 30 +++
 rtl/ofdm_sc_mapper.sv | 155 +++++++++++++++
 tb/tb_ofdm_sc_mapper.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_map_pkg.sv
// ----------------------------------------------------------------------------
// ofdm_map_pkg: shared codes, states and pilot constants for the OFDM subcarrier mapper. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
package ofdm_map_pkg;

  typedef enum logic [1:0] {
    CODE_NULL  = 2'b00,
    CODE_DATA  = 2'b01,
    CODE_PILOT = 2'b10,
    CODE_RSVD  = 2'b11
  } map_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam int          PILOT_AMP    = 11585;
  // Tap mask for x^11 + x^9 + 1 over state bits [10:0]
  localparam logic [10:0] LFSR_POLY    = 11'h500;
  localparam logic [10:0] LFSR_SEED    = 11'h7FF;
  localparam logic [2:0]  MAX_BW_INDEX = 3'd5;

endpackage
`default_nettype wire

// File: rtl/pilot_lfsr.sv
// ----------------------------------------------------------------------------
// pilot_lfsr: pilot sign sequence, reseedable, one step per pilot beat. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module pilot_lfsr
  import ofdm_map_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic adv,
  output logic bit_out
);

  logic [10:0] lfsr;

  assign bit_out = ^(lfsr & LFSR_POLY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (load) begin
      lfsr <= LFSR_SEED;
    end else if (adv) begin
      lfsr <= {lfsr[9:0], bit_out};
    end
  end

endmodule
`default_nettype wire

// File: rtl/ofdm_sc_mapper.sv
// ----------------------------------------------------------------------------
// ofdm_sc_mapper: walks the subcarrier map ROM and emits null/data/pilot beats in order. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module ofdm_sc_mapper
  import ofdm_map_pkg::*;
#(
  parameter int DEPTH_RAM = 10,
  parameter int FFTSIZE   = 1024,
  parameter int DW        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           index_bw,
  output logic [DEPTH_RAM-1:0] map_addr,
  output logic [2:0]           map_bw,
  input  logic [1:0]           map_code,
  input  logic                 s_valid,
  input  logic signed [DW-1:0] s_i,
  input  logic signed [DW-1:0] s_q,
  output logic                 s_ready,
  output logic                 m_valid,
  output logic signed [DW-1:0] m_i,
  output logic signed [DW-1:0] m_q,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 bw_err
);

  localparam logic [DEPTH_RAM-1:0] LAST_ADDR = DEPTH_RAM'(FFTSIZE - 1);
  localparam logic signed [DW-1:0] AMP_POS   = DW'(PILOT_AMP);
  localparam logic signed [DW-1:0] AMP_NEG   = DW'(-PILOT_AMP);

  logic [1:0] rst_sync;
  logic       rst_core_n;
  state_e     state;
  logic       cap_pend, cap_last;
  logic       buf_vld, buf_last;
  map_code_e  buf_code;
  map_code_e  head_code;
  logic       head_vld, head_last, head_fire, buf_vld_nx, issue;
  logic       start_ok, lfsr_adv, lfsr_bit;

  // Assertion is immediate; release reaches the core two clocks later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_core_n = rst_sync[1];

  // A code read is issued only when the buffer is guaranteed free for its arrival
  always_comb begin
    start_ok   = start && (state == ST_IDLE) && (index_bw <= MAX_BW_INDEX);
    head_vld   = buf_vld || cap_pend;
    head_code  = buf_vld ? buf_code : map_code_e'(map_code);
    head_last  = buf_vld ? buf_last : cap_last;
    head_fire  = head_vld && (!m_valid || m_ready) && ((head_code != CODE_DATA) || s_valid);
    buf_vld_nx = buf_vld ? (head_fire ? cap_pend : 1'b1) : (cap_pend && !head_fire);
    issue      = ((state == ST_PRIME) || (state == ST_RUN)) && !buf_vld_nx;
    s_ready    = head_fire && (head_code == CODE_DATA);
    lfsr_adv   = head_fire && (head_code == CODE_PILOT);
  end

  pilot_lfsr u_pilot_lfsr (
    .clk     (clk),
    .rst_n   (rst_core_n),
    .load    (start_ok),
    .adv     (lfsr_adv),
    .bit_out (lfsr_bit)
  );

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state    <= ST_IDLE;
      map_addr <= '0;
      map_bw   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bw_err   <= 1'b0;
      cap_pend <= 1'b0;
      cap_last <= 1'b0;
      buf_vld  <= 1'b0;
      buf_last <= 1'b0;
      buf_code <= CODE_NULL;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_i      <= '0;
      m_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state    <= ST_PRIME;
            map_addr <= '0;
            map_bw   <= index_bw;
            busy     <= 1'b1;
          end else if (start) begin
            bw_err <= 1'b1;
          end
        end
        ST_PRIME: state <= ST_RUN;
        ST_RUN: begin
          if (issue && (map_addr == LAST_ADDR)) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (m_valid && m_ready && m_last) begin
            state    <= ST_IDLE;
            map_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (issue && (map_addr != LAST_ADDR)) map_addr <= map_addr + 1'b1;
      cap_pend <= issue;
      cap_last <= issue && (map_addr == LAST_ADDR);

      buf_vld <= buf_vld_nx;
      if (!buf_vld || head_fire) begin
        buf_code <= map_code_e'(map_code);
        buf_last <= cap_last;
      end

      if (head_fire) begin
        m_valid <= 1'b1;
        m_last  <= head_last;
        case (head_code)
          CODE_DATA: begin
            m_i <= s_i;
            m_q <= s_q;
          end
          CODE_PILOT: begin
            m_i <= lfsr_bit ? AMP_NEG : AMP_POS;
            m_q <= '0;
          end
          default: begin
            m_i <= '0;
            m_q <= '0;
          end
        endcase
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ofdm_sc_mapper.sv
// ----------------------------------------------------------------------------
// tb_ofdm_sc_mapper: scoreboard bench for ofdm_sc_mapper with a registered map ROM model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module tb_ofdm_sc_mapper;
  import ofdm_map_pkg::PILOT_AMP;

  localparam int DEPTH_RAM = 4;
  localparam int FFTSIZE   = 16;
  localparam int DW        = 16;
  localparam logic [DW-1:0] AMP_P = DW'(PILOT_AMP);
  localparam logic [DW-1:0] AMP_N = DW'(-PILOT_AMP);

  typedef struct packed {
    logic [DW-1:0] i;
    logic [DW-1:0] q;
    logic          last;
  } beat_t;

  logic                 clk, rst_n, start, s_valid, s_ready, m_valid, m_last, m_ready;
  logic                 busy, done, bw_err;
  logic [2:0]           index_bw, map_bw;
  logic [DEPTH_RAM-1:0] map_addr;
  logic [1:0]           map_code;
  logic [DW-1:0]        s_i, s_q, m_i, m_q;

  logic [1:0]    rom [0:7][0:FFTSIZE-1];
  logic [DW-1:0] di [0:FFTSIZE-1];
  logic [DW-1:0] dq [0:FFTSIZE-1];
  beat_t         sb [$];

  int vectors = 0, miscompares = 0;
  int d_idx = 0, n_data = 0, gap_at = -1, gap = 0;
  int beats_acc = 0, bubbles = 0, sready_cnt = 0;
  logic rnd_ready = 1'b0, in_reset = 1'b1;

  ofdm_sc_mapper #(.DEPTH_RAM(DEPTH_RAM), .FFTSIZE(FFTSIZE), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .index_bw(index_bw),
    .map_addr(map_addr), .map_bw(map_bw), .map_code(map_code),
    .s_valid(s_valid), .s_i(s_i), .s_q(s_q), .s_ready(s_ready),
    .m_valid(m_valid), .m_i(m_i), .m_q(m_q), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done), .bw_err(bw_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) map_code <= rom[map_bw][map_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected beats for one symbol; pilot signs from x^11+x^9+1 seeded all-ones
  task automatic build_symbol(input int prof);
    logic [10:0] sr;
    logic        fb;
    beat_t       b;
    int          nd;
    sr = 11'h7FF;
    nd = 0;
    for (int k = 0; k < FFTSIZE; k++) begin
      b.last = (k == FFTSIZE - 1);
      case (rom[prof][k])
        2'd1: begin
          di[nd] = DW'($urandom);
          dq[nd] = DW'($urandom);
          b.i = di[nd];
          b.q = dq[nd];
          nd++;
        end
        2'd2: begin
          fb  = sr[10] ^ sr[8];
          b.i = fb ? AMP_N : AMP_P;
          b.q = '0;
          sr  = {sr[9:0], fb};
        end
        default: begin
          b.i = '0;
          b.q = '0;
        end
      endcase
      sb.push_back(b);
    end
    n_data = nd;
    d_idx  = 0;
  endtask

  task automatic run_symbol(input logic [2:0] prof);
    int lat, wc;
    @(negedge clk);
    build_symbol(int'(prof));
    beats_acc = 0; bubbles = 0; sready_cnt = 0;
    @(posedge clk); #2; start = 1'b1; index_bw = prof;
    @(posedge clk); #2; start = 1'b0;
    @(negedge clk);
    check("busy_after_start", 64'(busy), 64'(1));
    check("map_bw_latched", 64'(map_bw), 64'(prof));
    lat = 1;
    while (!m_valid && lat < 50) begin @(negedge clk); lat++; end
    check("first_valid_latency", 64'(lat), 64'(3));
    wc = 0;
    while (!done && wc < 300) begin @(negedge clk); wc++; end
    check("done_seen", 64'(done), 64'(1));
    check("sb_drained", 64'(sb.size()), 64'(0));
  endtask

  // Data source: presents item d_idx, optional 5-cycle gap before item gap_at
  initial begin : p_data
    logic hs;
    forever begin
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      if (hs) begin
        d_idx++;
        if (d_idx == gap_at) gap = 5;
      end
      if (gap > 0) begin
        s_valid = 1'b0;
        gap--;
      end else begin
        s_valid = (d_idx < n_data);
      end
      s_i = di[d_idx % FFTSIZE];
      s_q = dq[d_idx % FFTSIZE];
    end
  end

  initial begin : p_ready
    forever begin
      @(posedge clk); #1;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : p_monitor
    beat_t        eb;
    logic         stalled, exp_done;
    logic [33:0]  held;
    stalled = 1'b0; exp_done = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (in_reset) begin
        stalled = 1'b0; exp_done = 1'b0;
      end else begin
        if (done || exp_done) check("done_pulse", 64'(done), 64'(exp_done));
        exp_done = 1'b0;
        if (stalled) check("stall_hold", 64'({m_valid, m_last, m_i, m_q}), 64'(held));
        if (s_ready) sready_cnt++;
        if (!m_valid && beats_acc > 0 && sb.size() > 0) bubbles++;
        if (m_valid && m_ready) begin
          check("beat_expected", 64'(sb.size() > 0), 64'(1));
          if (sb.size() > 0) begin
            eb = sb.pop_front();
            check("beat_i", 64'(m_i), 64'(eb.i));
            check("beat_q", 64'(m_q), 64'(eb.q));
            check("beat_last", 64'(m_last), 64'(eb.last));
            if (eb.last) exp_done = 1'b1;
          end
          beats_acc++;
        end
        stalled = m_valid && !m_ready;
        held    = {m_valid, m_last, m_i, m_q};
      end
    end
  end

  initial begin : p_main
    int wc;
    rst_n = 1'b0; start = 1'b0; index_bw = '0;
    s_valid = 1'b0; s_i = '0; s_q = '0; m_ready = 1'b1;
    for (int p = 0; p < 8; p++)
      for (int k = 0; k < FFTSIZE; k++) rom[p][k] = 2'd0;
    // Profile 0: 4 null, 8 data, 2 pilot, 2 null
    for (int k = 4; k < 12; k++) rom[0][k] = 2'd1;
    rom[0][12] = 2'd2; rom[0][13] = 2'd2;
    // Profile 3: pilot-heavy with a reserved code, pilot first
    for (int k = 0; k < FFTSIZE; k++) rom[3][k] = 2'd2;
    rom[3][1] = 2'd1; rom[3][6] = 2'd1; rom[3][10] = 2'd1; rom[3][15] = 2'd1;
    rom[3][3] = 2'd3;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({map_addr, map_bw, s_ready, m_valid, m_i, m_q, m_last, busy, done, bw_err}), 64'(0));
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_reset = 1'b0;
    check("idle_after_release", 64'({m_valid, busy, map_addr}), 64'(0));

    run_symbol(3'd0);
    check("base_bubbles", 64'(bubbles), 64'(0));
    check("base_s_ready_pulses", 64'(sready_cnt), 64'(8));

    rnd_ready = 1'b1;
    run_symbol(3'd0);
    check("rand_ready_s_ready_pulses", 64'(sready_cnt), 64'(8));
    rnd_ready = 1'b0;

    gap_at = 3;
    run_symbol(3'd0);
    check("gap_bubbles", 64'(bubbles), 64'(5));
    check("gap_s_ready_pulses", 64'(sready_cnt), 64'(8));
    gap_at = -1;

    @(posedge clk); #2; start = 1'b1; index_bw = 3'd6;
    @(posedge clk); #2; start = 1'b0;
    @(negedge clk);
    check("bad_bw_err", 64'(bw_err), 64'(1));
    check("bad_bw_busy", 64'(busy), 64'(0));
    check("bad_bw_addr", 64'(map_addr), 64'(0));
    repeat (3) @(negedge clk);
    check("bad_bw_no_output", 64'({m_valid, busy}), 64'(0));
    run_symbol(3'd3);
    check("bw_err_sticky", 64'(bw_err), 64'(1));
    check("p3_s_ready_pulses", 64'(sready_cnt), 64'(4));

    @(negedge clk);
    build_symbol(0);
    beats_acc = 0;
    @(posedge clk); #2; start = 1'b1; index_bw = 3'd0;
    @(posedge clk); #2; start = 1'b0;
    wc = 0;
    while (beats_acc < 7 && wc < 100) begin @(negedge clk); wc++; end
    check("reached_beat7", 64'(beats_acc >= 7), 64'(1));
    #1;
    in_reset = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midsym_reset_outputs", 64'({map_addr, map_bw, s_ready, m_valid, m_i, m_q, m_last, busy, done, bw_err}), 64'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_reset = 1'b0;
    check("post_reset_idle", 64'({m_valid, busy}), 64'(0));
    run_symbol(3'd3);
    check("post_reset_s_ready_pulses", 64'(sready_cnt), 64'(4));

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
